// File: rtl/vga_timing.sv
// VGA raster timing generator: h/v counters, a fetch-request stage and a
// display stage one clock later, so pixel memory gets exactly one clock of latency.
module vga_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic       clk_25m,
   input  logic       rst,
   output logic       pix_req,
   output logic [9:0] req_x,
   output logic [9:0] req_y,
   output logic       de,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start,
   output logic       line_end
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [10:0] HA     = 11'(H_ACTIVE);
   localparam logic [10:0] VA     = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]  h, v;
   logic [10:0] hx, vx;
   logic        hs1, vs1, fs1, le1;
   logic        vis;

   assign hx  = {1'b0, h};
   assign vx  = {1'b0, v};
   assign vis = (hx < HA) && (vx < VA);

   always_ff @(posedge clk_25m) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + 10'd1;
      end else begin
         h <= h + 10'd1;
      end
   end

   // Fetch stage: coordinates only advance inside the visible area.
   always_ff @(posedge clk_25m) begin
      if (rst) begin
         pix_req <= 1'b0;
         req_x   <= '0;
         req_y   <= '0;
         hs1     <= 1'b0;
         vs1     <= 1'b0;
         fs1     <= 1'b0;
         le1     <= 1'b0;
      end else begin
         pix_req <= vis;
         if (vis) begin
            req_x <= h;
            req_y <= v;
         end
         hs1 <= (hx >= HS_BEG) && (hx < HS_END);
         vs1 <= (vx >= VS_BEG) && (vx < VS_END);
         fs1 <= (h == '0) && (v == '0);
         le1 <= (h == H_LAST);
      end
   end

   always_ff @(posedge clk_25m) begin
      if (rst) begin
         de          <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         frame_start <= 1'b0;
         line_end    <= 1'b0;
      end else begin
         de          <= pix_req;
         hsync       <= hs1 ? SYNC_POL : ~SYNC_POL;
         vsync       <= vs1 ? SYNC_POL : ~SYNC_POL;
         frame_start <= fs1;
         line_end    <= le1;
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default 640x480 timing on one instance and a
// tiny 8x6 raster with active-high syncs on a second.
module tb_vga_timing;

   logic       clk = 1'b0;
   logic       rst0, rst1;
   logic       pr0, de0, hs0, vs0, fs0, le0;
   logic [9:0] rx0, ry0;
   logic       pr1, de1, hs1, vs1, fs1, le1;
   logic [9:0] rx1, ry1;
   int         ram_q = 0;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   vga_timing u_dut0 (
      .clk_25m(clk), .rst(rst0), .pix_req(pr0), .req_x(rx0), .req_y(ry0),
      .de(de0), .hsync(hs0), .vsync(vs0), .frame_start(fs0), .line_end(le0)
   );

   vga_timing #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
   ) u_dut1 (
      .clk_25m(clk), .rst(rst1), .pix_req(pr1), .req_x(rx1), .req_y(ry1),
      .de(de1), .hsync(hs1), .vsync(vs1), .frame_start(fs1), .line_end(le1)
   );

   // One-clock-latency pixel RAM holding x + y*640.
   always @(posedge clk) ram_q <= int'(rx0) + int'(ry0) * 640;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rst0(input string tag);
      check({tag, " pix_req"}, int'(pr0), 0);
      check({tag, " de"}, int'(de0), 0);
      check({tag, " fs"}, int'(fs0), 0);
      check({tag, " le"}, int'(le0), 0);
      check({tag, " req_x"}, int'(rx0), 0);
      check({tag, " req_y"}, int'(ry0), 0);
      check({tag, " hsync"}, int'(hs0), 1);
      check({tag, " vsync"}, int'(vs0), 1);
   endtask

   initial begin
      int de_run, de_low, hs_first, hs_cnt;
      int le_first, le_cnt, fs_cnt, ex, ey;
      int fs_second, vs_first, vs_cnt, de_cnt;
      rst0 = 1'b1;
      rst1 = 1'b1;
      repeat (3) begin
         tick();
         check_rst0("rst");
         check("rst s.hsync", int'(hs1), 0);
         check("rst s.vsync", int'(vs1), 0);
      end

      rst0 = 1'b0;
      tick();
      check("rel1 pix_req", int'(pr0), 1);
      check("rel1 req_x", int'(rx0), 0);
      check("rel1 req_y", int'(ry0), 0);
      check("rel1 de", int'(de0), 0);
      tick();
      check("rel2 de", int'(de0), 1);
      check("rel2 fs", int'(fs0), 1);

      de_run = 0; de_low = -1; hs_first = -1; hs_cnt = 0;
      le_first = -1; le_cnt = 0; fs_cnt = 0; ex = 0; ey = 0;
      for (int c = 0; c < 2400; c++) begin
         if (de0) begin
            check("pixel", ram_q, ex + ey * 640);
            ex++;
            if (ex == 640) begin
               ex = 0;
               ey++;
            end
         end
         if (c < 800) begin
            if (de_low < 0 && de0) de_run++;
            if (de_low < 0 && !de0) de_low = c;
            if (!hs0) begin
               if (hs_first < 0) hs_first = c;
               hs_cnt++;
            end
         end
         if (le0) begin
            if (le_first < 0) le_first = c;
            le_cnt++;
         end
         if (fs0) fs_cnt++;
         tick();
      end
      check("de run", de_run, 640);
      check("de low at", de_low, 640);
      check("hs start", hs_first, 656);
      check("hs width", hs_cnt, 96);
      check("le first", le_first, 799);
      check("le count", le_cnt, 3);
      check("fs count", fs_cnt, 1);
      check("lines done", ey, 3);
      check("line tail", ex, 0);
      check("line4 de", int'(de0), 1);

      repeat (300) tick();
      check("mid req_x", int'(rx0), 301);
      check("mid req_y", int'(ry0), 3);
      rst0 = 1'b1;
      repeat (3) begin
         tick();
         check_rst0("mid rst");
      end
      rst0 = 1'b0;
      tick();
      check("mrel1 pix_req", int'(pr0), 1);
      check("mrel1 req_x", int'(rx0), 0);
      check("mrel1 req_y", int'(ry0), 0);
      check("mrel1 de", int'(de0), 0);
      check("mrel1 fs", int'(fs0), 0);
      tick();
      check("mrel2 de", int'(de0), 1);
      check("mrel2 fs", int'(fs0), 1);
      check("mrel2 hsync", int'(hs0), 1);

      rst1 = 1'b0;
      tick();
      check("s.rel1 pix_req", int'(pr1), 1);
      check("s.rel1 de", int'(de1), 0);
      tick();
      check("s.rel2 de", int'(de1), 1);
      check("s.rel2 fs", int'(fs1), 1);

      fs_cnt = 0; fs_second = -1; hs_first = -1; hs_cnt = 0;
      vs_first = -1; vs_cnt = 0; de_cnt = 0; le_first = -1; le_cnt = 0;
      for (int c = 0; c <= 96; c++) begin
         if (fs1) begin
            fs_cnt++;
            if (fs_cnt == 2) fs_second = c;
         end
         if (c < 48) begin
            if (hs1) begin
               if (hs_first < 0) hs_first = c;
               hs_cnt++;
            end
            if (vs1) begin
               if (vs_first < 0) vs_first = c;
               vs_cnt++;
            end
            if (de1) de_cnt++;
            if (le1) begin
               if (le_first < 0) le_first = c;
               le_cnt++;
            end
         end
         tick();
      end
      check("s.fs count", fs_cnt, 3);
      check("s.frame period", fs_second, 48);
      check("s.hs start", hs_first, 5);
      check("s.hs clocks", hs_cnt, 12);
      check("s.vs start", vs_first, 32);
      check("s.vs clocks", vs_cnt, 8);
      check("s.de clocks", de_cnt, 12);
      check("s.le first", le_first, 7);
      check("s.le count", le_cnt, 6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL expose the following parameters, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, hsync pulse width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_POL, 0, sync pulse level (0 = active-low)

REQ-002 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk_25m, in, 1, pixel clock; only clock; all logic on rising edge
- rst, in, 1, synchronous, active-high reset
- pix_req, out, 1, pixel fetch request; high when the request address is in the visible area
- req_x, out, 10, fetch column, valid while pix_req=1
- req_y, out, 10, fetch row, valid while pix_req=1
- de, out, 1, display enable; pix_req delayed 1 clock
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- frame_start, out, 1, one-clock pulse with de at pixel (0,0)
- line_end, out, 1, one-clock pulse on the last clock of every line (H_TOTAL-1)

Function
REQ-003 SHALL derive H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Both totals SHALL be at most 1024.
REQ-004 SHALL keep a horizontal counter h and a vertical counter v, each 10 bits.
- h counts 0..H_TOTAL-1 and then wraps to 0.
- v increments only when h wraps, and wraps V_TOTAL-1 -> 0 in the same clock that h wraps.
REQ-005 SHALL register stage 1 from the (h,v) values of clock t, valid in clock t+1:
- pix_req = (h<H_ACTIVE && v<V_ACTIVE)
- req_x = h
- req_y = v
REQ-006 SHALL register stage 2 from the (h,v) values of clock t, valid in clock t+2:
- de = stage-1 pix_req delayed one clock
- hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (default 656..751)
- vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (default 490..491), for whole lines, changing at h=0
- frame_start asserted for h=0, v=0
- line_end asserted for h=H_TOTAL-1
REQ-007 SHALL drive a sync output at level SYNC_POL when asserted and at ~SYNC_POL when deasserted.
REQ-008 SHALL give pixel data a fixed fetch latency of exactly 1 clock: memory read at req_x/req_y is consumed in the clock where de is high.
REQ-009 SHALL keep req_x and req_y at their last value while pix_req=0; they are don't-care there but SHALL NOT be X.
REQ-010 SHALL never combinationally decode any output; every output is a register.
REQ-011 SHALL make the frame period exactly H_TOTAL*V_TOTAL clocks (default 420000), with no dropped or extra clocks at wrap.

Reset
REQ-012 SHALL, while rst=1 at a rising edge, set:
- h=0, v=0
- pix_req=0, de=0, frame_start=0, line_end=0
- req_x=0, req_y=0
- hsync=~SYNC_POL, vsync=~SYNC_POL
REQ-013 SHALL restart from (0,0) when reset is applied mid-line or mid-frame, with no residual pulses.
- At the 1st edge after rst falls: counters become (1,0) and pix_req=1 with req_x=0, req_y=0.
- At the 2nd edge: de=1 and frame_start=1.
REQ-014 SHALL produce no output change other than the reset values while rst=1.

Verification
REQ-015 SHALL cover these scenarios:
- Reset release, defaults -> pix_req=1, req=(0,0) one clock after release; de=1 and frame_start=1 two clocks after release; frame_start repeats every 420000 clocks.
- Line timing -> de high for exactly 640 consecutive clocks, then low for 160; hsync low (SYNC_POL=0) from 656 to 751 clocks after de rises (96 clocks); line_end every 800 clocks.
- Frame timing -> de active on 480 lines; vsync low for exactly 1600 clocks, starting 490*800 clocks after frame_start.
- Fetch alignment -> a 1-clock-latency RAM model returns x+y*640 at req; every pixel sampled with de=1 equals the expected pixel for its (x,y) position, with no off-by-one.
- Reset mid-line (at h=300, v=100) for 3 clocks -> outputs at reset values during reset; after release, same sequence as the first scenario.
- Small parameters (4,1,2,1 / 3,1,1,1), SYNC_POL=1 -> H_TOTAL=8, V_TOTAL=6; hsync high at h=5..6; vsync high on line 4; frame period 48 clocks.
